// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request, direct-write and result bundle
// for the iterative multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             wehi;
   logic             welo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             dbz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, srca, srcb,
      output wehi, welo, wdata,
      input  busy, done, dbz, hi, lo
   );

   modport slave (
      input  start, op, srca, srcb,
      input  wehi, welo, wdata,
      output busy, done, dbz, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 shift-add multiply / restoring divide
// on operand magnitudes, with architectural HI/LO registers.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state;
   state_t nstate;

   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   mq;
   logic [WIDTH-1:0]   m;
   logic               isdiv;
   logic               rneg;
   logic               dneg;
   logic               zdiv;
   logic               done;
   logic               dbz;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;

   logic               accept;
   logic               wr_ok;
   logic [WIDTH-1:0]   amag;
   logic [WIDTH-1:0]   bmag;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shl;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Signed ops work on magnitudes; MIN maps to itself as unsigned.
   assign amag = (bus.op[0] && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
   assign bmag = (bus.op[0] && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;

   // Multiply step: add multiplicand when multiplier LSB is set.
   assign sum = acc + (mq[0] ? {1'b0, m} : '0);

   // Divide step: shift in next dividend bit, trial-subtract divisor.
   // Remainder is one bit wider so the borrow lands in the MSB.
   assign shl   = {acc[WIDTH-1:0], mq[WIDTH-1]};
   assign trial = shl - {1'b0, m};

   assign prod     = {acc[WIDTH-1:0], mq};
   assign prod_fix = rneg ? -prod : prod;
   assign quo_fix  = zdiv ? '1 : (rneg ? -mq : mq);
   assign rem_fix  = dneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nstate;
   end

   // Next-state logic: CALC runs until the counter drains, FIX is one cycle.
   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (bus.start) nstate = CALC;
         CALC:    if (cnt == CNT_W'(1)) nstate = FIX;
         FIX:     nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Output decode: start beats direct writes; both ignored while busy.
   always_comb begin
      bus.busy = (state != IDLE);
      accept   = (state == IDLE) && bus.start;
      wr_ok    = (state == IDLE) && !bus.start;
   end

   // Datapath: operand latch, one iteration per CALC cycle, HI/LO update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         acc   <= '0;
         mq    <= '0;
         m     <= '0;
         isdiv <= 1'b0;
         rneg  <= 1'b0;
         dneg  <= 1'b0;
         zdiv  <= 1'b0;
         done  <= 1'b0;
         dbz   <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            isdiv <= bus.op[1];
            mq    <= bus.op[1] ? amag : bmag;
            m     <= bus.op[1] ? bmag : amag;
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH);
            rneg  <= bus.op[0] & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            dneg  <= bus.op[0] & bus.srca[WIDTH-1];
            zdiv  <= bus.op[1] & (bus.srcb == '0);
            dbz   <= 1'b0;
         end else if (state == CALC) begin
            cnt <= cnt - CNT_W'(1);
            if (isdiv) begin
               if (!trial[WIDTH]) begin
                  acc <= trial;
                  mq  <= {mq[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= shl;
                  mq  <= {mq[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc <= {1'b0, sum[WIDTH:1]};
               mq  <= {sum[0], mq[WIDTH-1:1]};
            end
         end else if (state == FIX) begin
            if (isdiv) begin
               hi  <= rem_fix;
               lo  <= quo_fix;
               dbz <= zdiv;
            end else begin
               {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
         end else if (wr_ok) begin
            if (bus.wehi) hi <= bus.wdata;
            if (bus.welo) lo <= bus.wdata;
         end
      end
   end

   assign bus.done = done;
   assign bus.dbz  = dbz;
   assign bus.hi   = hi;
   assign bus.lo   = lo;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It takes RD1/RD2 operands from the register file and runs one of four operations: MULT, MULTU, DIV or DIVU. A radix-2 shift-add or restoring-divide engine produces one bit per cycle. The unit signals busy and done so the controller can stall on MFHI/MFLO, and it accepts direct HI/LO writes (MTHI/MTLO).

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; even, ≥ 4
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; low clears all state immediately
- start  input  1  request; sampled only when busy=0
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- srca  input  WIDTH  multiplicand / dividend
- srcb  input  WIDTH  multiplier / divisor
- wehi  input  1  direct write of wdata into HI (MTHI)
- welo  input  1  direct write of wdata into LO (MTLO)
- wdata  input  WIDTH  data for wehi/welo
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle
- dbz  output  1  divide-by-zero flag; valid with done, holds until the next accepted start
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- FSM states are IDLE, CALC and FIX. Reset puts the FSM in IDLE.
- **IDLE**
  - Transition: start=1 at an edge → CALC.
  - At that edge, latch the operand magnitudes: abs() for signed ops, raw values for unsigned ops.
  - Also latch the result sign and dividend sign, clear the internal accumulator, and load counter = WIDTH.
- **CALC**
  - Each edge performs one iteration and decrements the counter. When counter reaches 0 → FIX.
  - Multiply: 2·WIDTH-bit shift-add, LSB-first.
  - Divide: restoring divide, MSB-first. The remainder register is WIDTH+1 bits so the subtraction has no overflow.
- **FIX** (one edge)
  - Apply two's-complement sign correction and write HI/LO.
  - Pulse done and return to IDLE.
- Results:
  - MULT/MULTU: {HI,LO} = full 2·WIDTH-bit product.
  - DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Divide by zero (DIV or DIVU): HI = srca as latched, LO = all ones, dbz=1. Latency is the same as a normal divide.
  - DIV of MIN by −1: LO = MIN, HI = 0, dbz=0. This falls out naturally from the magnitude algorithm with unsigned WIDTH-bit magnitudes.
- HI/LO keep their previous values throughout CALC and change only at the FIX edge. All internal working registers are separate from HI/LO.
- Direct writes (wehi/welo):
  - Effective at the next edge only when busy=0 and no start is accepted at that edge.
  - If a start is accepted at the same edge, start wins and the writes are dropped.
  - Writes are ignored while busy=1.
  - wehi and welo may be asserted together.
- dbz clears on any accepted start.

## Timing
- A start is accepted at edge k.
  - busy=1 from after edge k through edge k+WIDTH+1.
  - At edge k+WIDTH+1, done=1 and busy=0, and HI/LO are valid.
- Latency: WIDTH+1 cycles from accept to done. For WIDTH=32, done rises 33 edges after accept.
- done lasts exactly one cycle. A new start may be accepted in the done cycle, giving back-to-back throughput of one op per WIDTH+1 cycles.
- start while busy=1 is ignored and not queued.
- op/srca/srcb need only be valid in the accept cycle.
- Reset low at any time, including mid-CALC, forces immediately:
  - state IDLE
  - busy=0, done=0, dbz=0
  - hi=0, lo=0
  - counter=0
- Release of reset is synchronous with no extra wait. start is honoured at the first edge after release.
- Reset values: busy 0, done 0, dbz 0, hi 0, lo 0.

## Test plan
1. MULT srca=0xFFFFFFFD (−3), srcb=7 → after 33 edges: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
2. MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MULT of the same operands → hi=0, lo=1.
3. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 7/−2 → lo=0xFFFFFFFD, hi=1.
4. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, dbz=0. DIVU 5/0 → hi=5, lo=0xFFFFFFFF, dbz=1; dbz cleared by the next start.
5. Handshake and write rules, from idle with hi=lo=0:
   - wehi with wdata=0x1234 → hi=0x1234.
   - start MULTU 2×3 with a second start and welo (wdata=0xAAAA) mid-CALC → the extra start and the write are ignored; done once with hi=0, lo=6; hi holds 0x1234 until FIX.
   - start asserted in the done cycle → accepted.
6. Assert reset low at edge 10 of a DIVU 100/7 → busy, hi and lo all 0 with no clock edge. After release, a fresh DIVU 100/7 → lo=14, hi=2 after 33 edges.
